// File: rtl/lzw_pkg.sv
// lzw_pkg: constants shared by the LZW compressor output packer and the decompressor input register
package lzw_pkg;
  localparam int CODE_W = 13;
  localparam int BYTE_W = 8;
  localparam int BUF_W = 32;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CODE_W-1:0] EOS_CODE = 13'h1FFF;
endpackage

// File: rtl/lzw_inreg.sv
// lzw_inreg: unpacks an MSB-first LZW byte stream into 13-bit codes and drops the pad after the EOS code
module lzw_inreg
  import lzw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              byte_ready,
  output logic              code_valid,
  output logic [CODE_W-1:0] code_out,
  output logic              code_eos,
  input  logic              code_ready,
  output logic              idle
);
  logic [BUF_W-1:0] bits, bits_pop, bits_nxt;
  logic [CNT_W-1:0] cnt, rem, shamt, cnt_pop, cnt_nxt;
  logic pop, accept;
  assign byte_ready = cnt <= CNT_W'(BUF_W - BYTE_W);
  assign code_valid = cnt >= CNT_W'(CODE_W);
  assign code_out = bits[BUF_W-1 -: CODE_W];
  assign code_eos = code_valid && (code_out == EOS_CODE);
  assign idle = cnt == '0;
  assign pop = code_valid & code_ready;
  assign accept = byte_valid & byte_ready;
  assign rem = cnt - CNT_W'(CODE_W);
  // pop first (the EOS pop also swallows the pad up to the next byte boundary), then insert the byte just below the valid bits
  always_comb begin
    shamt = code_eos ? CNT_W'(CODE_W) + (rem & CNT_W'(BYTE_W - 1)) : CNT_W'(CODE_W);
    cnt_pop = pop ? (code_eos ? rem & ~CNT_W'(BYTE_W - 1) : rem) : cnt;
    bits_pop = pop ? bits << shamt : bits;
    bits_nxt = accept ? bits_pop | ({byte_in, {(BUF_W - BYTE_W){1'b0}}} >> cnt_pop) : bits_pop;
    cnt_nxt = accept ? cnt_pop + CNT_W'(BYTE_W) : cnt_pop;
  end
  // bit buffer and valid-bit count; clear discards any same-cycle accept or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
      cnt <= '0;
    end else if (clr) begin
      bits <= '0;
      cnt <= '0;
    end else begin
      bits <= bits_nxt;
      cnt <= cnt_nxt;
    end
  end
endmodule
